wb_ram_slave: RTL and testbench

Wishbone B4 classic single-port RAM responder with programmable wait states. It sits on the slave side of `wb_intercon`, taking one `i2s_stb_o` bit plus the shared `cyc`/`adr`/`dat`/`sel`/`we` lines. It answers each transfer with exactly one registered `ack_o` pulse, or `err_o` pulse, after a fixed latency.

---
 rtl/wb_ram_slave_pkg.sv | 13 +
 rtl/wb_ram_slave_mem.sv | 40 ++++
 rtl/wb_ram_slave.sv | 147 ++++++++++++++
 tb/tb_wb_ram_slave.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_slave_pkg.sv
// Shared types for the Wishbone RAM responder: FSM state encoding and wait-counter width.
package wb_ram_slave_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_WAIT = 2'd1,
    STATE_RESP = 2'd2
  } state_t;

  // Wide enough for WAIT_STATES up to 15.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/wb_ram_slave_mem.sv
// Synchronous word RAM with per-byte write enables and a registered, resettable read port.
module wb_ram_slave_mem #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  input  logic [DATA_WIDTH/8-1:0]    i_wbe,
  input  logic                       i_re,
  output logic [DATA_WIDTH-1:0]      o_rdata
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array contents are deliberately never reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < SEL_WIDTH; k++) begin
      if (i_wbe[k]) begin
        r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  // Output register only loads on a read, so it holds the last read word otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic RAM responder with programmable wait states.
// Define WB_RAM_SLAVE_ERR_EN to answer out-of-range addresses with err_o instead of wrapping.
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic                    ack_o,
  output logic                    err_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [1:0]              dbg_state_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(DEPTH);

`ifdef WB_RAM_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_enter_resp;
  logic [WAIT_CNT_W-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [SEL_WIDTH-1:0]    r_sel;
  logic                    r_ack;
  logic                    r_err;

  logic                    w_req;
  logic                    w_idle;
  logic [ADDR_WIDTH-1:0]   w_req_adr;
  logic                    w_req_we;
  logic [DATA_WIDTH-1:0]   w_req_dat;
  logic [SEL_WIDTH-1:0]    w_req_sel;
  logic                    w_oor;
  logic [SEL_WIDTH-1:0]    w_mem_wbe;
  logic                    w_mem_re;

  assign w_req  = cyc_i & stb_i;
  assign w_idle = (r_state == STATE_IDLE);

  // With zero wait states RESP is entered straight from IDLE, before the latches load,
  // so the memory access must use the live bus inputs in that case.
  assign w_req_adr = w_idle ? adr_i : r_adr;
  assign w_req_we  = w_idle ? we_i  : r_we;
  assign w_req_dat = w_idle ? dat_i : r_dat;
  assign w_req_sel = w_idle ? sel_i : r_sel;

  assign w_oor = ERR_EN && (32'(w_req_adr) >= 32'(DEPTH));

  always_comb begin
    w_next_state = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      STATE_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_next_state = STATE_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = STATE_WAIT;
          end
        end
      end
      STATE_WAIT: begin
        if (!cyc_i) begin
          w_next_state = STATE_IDLE;
        end else if (r_cnt == WAIT_CNT_W'(1)) begin
          w_next_state = STATE_RESP;
          w_enter_resp = 1'b1;
        end
      end
      STATE_RESP: w_next_state = STATE_IDLE;
      default:    w_next_state = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= STATE_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_adr <= '0;
      r_we  <= 1'b0;
      r_dat <= '0;
      r_sel <= '0;
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_enter_resp & ~w_oor;
      r_err <= w_enter_resp &  w_oor;
      if (w_idle && w_req) begin
        r_adr <= adr_i;
        r_we  <= we_i;
        r_dat <= dat_i;
        r_sel <= sel_i;
        r_cnt <= WAIT_CNT_W'(WAIT_STATES);
      end else if (r_state == STATE_WAIT) begin
        r_cnt <= r_cnt - WAIT_CNT_W'(1);
      end
    end
  end

  // Reset on the commit edge must suppress the access, hence the explicit rst_i gate.
  assign w_mem_wbe = (w_enter_resp && w_req_we && !w_oor && !rst_i) ? w_req_sel : '0;
  assign w_mem_re  = w_enter_resp && !w_req_we && !w_oor && !rst_i;

  wb_ram_slave_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_addr  (w_req_adr[IDX_W-1:0]),
    .i_wdata (w_req_dat),
    .i_wbe   (w_mem_wbe),
    .i_re    (w_mem_re),
    .o_rdata (dat_o)
  );

  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: three instances with WAIT_STATES 1, 0 and 3 on one clock.
module tb_wb_ram_slave;
  import wb_ram_slave_pkg::*;

  localparam int NI = 3;

  logic        clk;
  logic        rst;
  logic        cyc      [NI];
  logic        stb      [NI];
  logic        we_s     [NI];
  logic [11:0] adr_s    [NI];
  logic [31:0] dat_s    [NI];
  logic [3:0]  sel_s    [NI];
  logic        ack      [NI];
  logic        err      [NI];
  logic [31:0] rdat     [NI];
  logic [1:0]  dbg_state[NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word array per instance plus the last word each instance returned.
  logic [31:0] model_mem [NI][1024];
  logic [31:0] last_rd   [NI];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  wb_ram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we_s[0]),
    .adr_i(adr_s[0]), .dat_i(dat_s[0]), .sel_i(sel_s[0]), .ack_o(ack[0]),
    .err_o(err[0]), .dat_o(rdat[0]), .dbg_state_o(dbg_state[0]));

  wb_ram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we_s[1]),
    .adr_i(adr_s[1]), .dat_i(dat_s[1]), .sel_i(sel_s[1]), .ack_o(ack[1]),
    .err_o(err[1]), .dat_o(rdat[1]), .dbg_state_o(dbg_state[1]));

  wb_ram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we_s[2]),
    .adr_i(adr_s[2]), .dat_i(dat_s[2]), .sel_i(sel_s[2]), .ack_o(ack[2]),
    .err_o(err[2]), .dat_o(rdat[2]), .dbg_state_o(dbg_state[2]));

  // ---------------- model helpers ----------------
  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  function automatic bit is_oor(input logic [11:0] adr);
`ifdef WB_RAM_SLAVE_ERR_EN
    return (int'(adr) >= 1024);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  task automatic model_write(input int d, input logic [11:0] adr, input logic [31:0] wd,
                             input logic [3:0] sel);
    if (!is_oor(adr)) model_mem[d][int'(adr) % 1024] = merge(model_mem[d][int'(adr) % 1024], wd, sel);
  endtask

  // ---------------- driver ----------------
  task automatic do_xfer(input int d, input bit we, input logic [11:0] adr, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat,
                         output bit got_ack, output bit got_err);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we_s[d] = we;
    adr_s[d] = adr; dat_s[d] = wd; sel_s[d] = sel;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    while (lat < 40 && !got_ack && !got_err) begin
      @(negedge clk);
      lat++;
      got_ack = (ack[d] === 1'b1);
      got_err = (err[d] === 1'b1);
      rd      = rdat[d];
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < NI; d++) begin
      cyc[d] = 0; stb[d] = 0; we_s[d] = 0; adr_s[d] = '0; dat_s[d] = '0; sel_s[d] = '0;
      last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      n_checks++;
      if (ack[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b want 0", d, ack[d]); end
      n_checks++;
      if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); end
      n_checks++;
      if (rdat[d] !== 32'h0) begin n_fail++; $display("FAIL reset_dat[%0d]: got %h want 0", d, rdat[d]); end
      n_checks++;
      if (dbg_state[d] !== 2'(STATE_IDLE)) begin
        n_fail++; $display("FAIL reset_state[%0d]: got %0d want IDLE", d, dbg_state[d]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; int lat; bit a, e;
    do_xfer(0, 1'b1, 12'd5, 32'hDEADBEEF, 4'hF, rd, lat, a, e);
    model_write(0, 12'd5, 32'hDEADBEEF, 4'hF);
    n_checks++;
    if (!a || e || lat != 2) begin
      n_fail++; $display("FAIL basic_wr_lat: ack=%b err=%b lat=%0d want ack=1 err=0 lat=2", a, e, lat);
    end
    @(negedge clk);
    n_checks++;
    if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: ack=%b want 0", ack[0]); end
    do_xfer(0, 1'b0, 12'd5, 32'h0, 4'h0, rd, lat, a, e);
    n_checks++;
    if (!a || lat != 2) begin n_fail++; $display("FAIL basic_rd_lat: ack=%b lat=%0d want ack=1 lat=2", a, lat); end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
    last_rd[0] = 32'hDEADBEEF;
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; int lat; bit a, e;
    do_xfer(0, 1'b1, 12'd7, 32'h11223344, 4'hF, rd, lat, a, e);
    model_write(0, 12'd7, 32'h11223344, 4'hF);
    do_xfer(0, 1'b1, 12'd7, 32'hAABBCCDD, 4'h5, rd, lat, a, e);
    model_write(0, 12'd7, 32'hAABBCCDD, 4'h5);
    n_checks++;
    if (rd !== last_rd[0]) begin n_fail++; $display("FAIL be_write_keeps_dat: got %h want %h", rd, last_rd[0]); end
    do_xfer(0, 1'b0, 12'd7, 32'h0, 4'h1, rd, lat, a, e);
    n_checks++;
    if (!a || rd !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL be_read: ack=%b got %h want 11bb33dd", a, rd);
    end
    last_rd[0] = 32'h11BB33DD;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat; bit a, e; logic [31:0] wd; int n_acks;
    for (int i = 0; i < 3; i++) begin
      wd = $urandom;
      do_xfer(1, 1'b1, 12'(i), wd, 4'hF, rd, lat, a, e);
      model_write(1, 12'(i), wd, 4'hF);
      n_checks++;
      if (!a || lat != 1) begin n_fail++; $display("FAIL b2b_init_lat: ack=%b lat=%0d want 1", a, lat); end
    end
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we_s[1] = 1'b0; adr_s[1] = 12'd0; sel_s[1] = 4'(($urandom_range(0, 15)));
    n_acks = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (ack[1] !== ((c % 2) == 1)) begin
        n_fail++; $display("FAIL b2b_ack_cycle%0d: got %b want %b", c, ack[1], (c % 2) == 1);
      end
      if (ack[1] === 1'b1 && n_acks < 3) begin
        n_checks++;
        if (rdat[1] !== model_mem[1][n_acks]) begin
          n_fail++; $display("FAIL b2b_data%0d: got %h want %h", n_acks, rdat[1], model_mem[1][n_acks]);
        end
        last_rd[1] = model_mem[1][n_acks];
        n_acks++;
        if (n_acks == 3) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
        else adr_s[1] = 12'(n_acks);
      end
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat; bit a, e; bit seen;
    do_xfer(2, 1'b1, 12'd9, 32'hCAFEF00D, 4'hF, rd, lat, a, e);
    model_write(2, 12'd9, 32'hCAFEF00D, 4'hF);
    n_checks++;
    if (!a || lat != 4) begin n_fail++; $display("FAIL abort_prewrite_lat: ack=%b lat=%0d want 4", a, lat); end
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we_s[2] = 1'b1; adr_s[2] = 12'd9; dat_s[2] = 32'h12345678; sel_s[2] = 4'hF;
    @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (ack[2] !== 1'b0 || err[2] !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL abort_no_ack: got a response want none"); end
    // Strobe without cycle must be ignored.
    stb[2] = 1'b1; we_s[2] = 1'b1; dat_s[2] = 32'h0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (ack[2] !== 1'b0) seen = 1'b1; end
    stb[2] = 1'b0;
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL stb_without_cyc: got ack want none"); end
    do_xfer(2, 1'b0, 12'd9, 32'h0, 4'hF, rd, lat, a, e);
    n_checks++;
    if (!a || rd !== model_mem[2][9]) begin
      n_fail++; $display("FAIL abort_readback: ack=%b got %h want %h", a, rd, model_mem[2][9]);
    end
    last_rd[2] = model_mem[2][9];
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; int lat; bit a, e; bit seen;
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we_s[2] = 1'b1; adr_s[2] = 12'd9; dat_s[2] = 32'h0BADBEEF; sel_s[2] = 4'hF;
    @(negedge clk);
    n_checks++;
    if (dbg_state[2] !== 2'(STATE_WAIT)) begin
      n_fail++; $display("FAIL rstwait_in_wait: state=%0d want WAIT", dbg_state[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    for (int d = 0; d < NI; d++) last_rd[d] = '0;
    n_checks++;
    if (ack[2] !== 1'b0 || err[2] !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_resp: ack=%b err=%b want 0 0", ack[2], err[2]);
    end
    n_checks++;
    if (dbg_state[2] !== 2'(STATE_IDLE)) begin
      n_fail++; $display("FAIL rstwait_state: state=%0d want IDLE", dbg_state[2]);
    end
    n_checks++;
    if (rdat[2] !== 32'h0) begin n_fail++; $display("FAIL rstwait_dat: got %h want 0", rdat[2]); end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (ack[2] !== 1'b0 || err[2] !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL rstwait_late_resp: got a response want none"); end
    do_xfer(2, 1'b0, 12'd9, 32'h0, 4'hF, rd, lat, a, e);
    n_checks++;
    if (rd !== model_mem[2][9]) begin
      n_fail++; $display("FAIL rstwait_no_write: got %h want %h", rd, model_mem[2][9]);
    end
    last_rd[2] = model_mem[2][9];
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat; bit a, e; logic [31:0] wd;
    wd = $urandom;
    do_xfer(0, 1'b1, 12'd0, wd, 4'hF, rd, lat, a, e);
    model_write(0, 12'd0, wd, 4'hF);
    do_xfer(0, 1'b0, 12'd0, 32'h0, 4'hF, rd, lat, a, e);
    last_rd[0] = model_mem[0][0];
    do_xfer(0, 1'b0, 12'h400, 32'h0, 4'hF, rd, lat, a, e);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL oor_rd_lat: got %0d want 2", lat); end
`ifdef WB_RAM_SLAVE_ERR_EN
    n_checks++;
    if (!e || a) begin n_fail++; $display("FAIL oor_rd_err: ack=%b err=%b want ack=0 err=1", a, e); end
    n_checks++;
    if (rd !== last_rd[0]) begin n_fail++; $display("FAIL oor_rd_dat_hold: got %h want %h", rd, last_rd[0]); end
`else
    n_checks++;
    if (!a || e) begin n_fail++; $display("FAIL oor_rd_ack: ack=%b err=%b want ack=1 err=0", a, e); end
    n_checks++;
    if (rd !== model_mem[0][0]) begin n_fail++; $display("FAIL oor_rd_wrap: got %h want %h", rd, model_mem[0][0]); end
    last_rd[0] = model_mem[0][0];
`endif
    wd = $urandom;
    do_xfer(0, 1'b1, 12'h400, wd, 4'hF, rd, lat, a, e);
    model_write(0, 12'h400, wd, 4'hF);
    do_xfer(0, 1'b0, 12'd0, 32'h0, 4'hF, rd, lat, a, e);
    n_checks++;
    if (!a || rd !== model_mem[0][0]) begin
      n_fail++; $display("FAIL oor_wr_effect: ack=%b got %h want %h", a, rd, model_mem[0][0]);
    end
    last_rd[0] = model_mem[0][0];
  endtask

  task automatic test_random();
    logic [31:0] rd; int lat; bit a, e; logic [31:0] wd; logic [11:0] adr; logic [3:0] sel; bit we;
    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        do_xfer(d, 1'b1, 12'(i), wd, 4'hF, rd, lat, a, e);
        model_write(d, 12'(i), wd, 4'hF);
      end
      for (int n = 0; n < 60; n++) begin
        we  = 1'($urandom_range(0, 1));
        adr = 12'($urandom_range(0, 15));
        wd  = $urandom;
        sel = 4'($urandom_range(0, 15));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_xfer(d, we, adr, wd, sel, rd, lat, a, e);
        n_checks++;
        if (!a || e || lat != ws_of(d) + 1) begin
          n_fail++; $display("FAIL rnd_lat[%0d]: ack=%b err=%b lat=%0d want lat %0d", d, a, e, lat, ws_of(d) + 1);
        end
        if (we) begin
          model_write(d, adr, wd, sel);
          n_checks++;
          if (rd !== last_rd[d]) begin
            n_fail++; $display("FAIL rnd_wr_hold[%0d]: got %h want %h", d, rd, last_rd[d]);
          end
        end else begin
          n_checks++;
          if (rd !== model_mem[d][int'(adr)]) begin
            n_fail++; $display("FAIL rnd_rd[%0d] adr %0d: got %h want %h", d, adr, rd, model_mem[d][int'(adr)]);
          end
          last_rd[d] = model_mem[d][int'(adr)];
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_byte_enables();
    test_back_to_back();
    test_abort();
    test_reset_mid_wait();
    test_out_of_range();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
